// File: rtl/term_pkg.sv
// term_ctrl shared definitions:
// screen geometry, control codes, FSM states and canned operations.
package term_pkg;

  localparam int COLS = 80;
  localparam int ROWS = 25;

  localparam logic [10:0] SCREEN   = 11'(COLS * ROWS);
  localparam logic [10:0] LAST_ROW = 11'(COLS * (ROWS - 1));
  localparam logic [6:0]  COL_MAX  = 7'(COLS - 1);
  localparam logic [4:0]  ROW_MAX  = 5'(ROWS - 1);

  localparam logic [7:0] BLANK = 8'h20;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] BS    = 8'h08;
  localparam logic [7:0] FF    = 8'h0C;

  typedef enum logic [2:0] {
    S_INIT_WAIT,
    S_INIT_CLR,
    S_IDLE,
    S_DECODE,
    S_ISSUE,
    S_WAIT,
    S_NEXT
  } state_e;

  typedef struct packed {
    logic [10:0] addr_b;
    logic [10:0] addr_e;
    logic [7:0]  data;
    logic [7:0]  off;
  } wr_op_t;

  localparam wr_op_t OP_CLEAR = {11'd0, SCREEN, BLANK, 8'd0};
  localparam wr_op_t OP_COPY  = {11'd0, LAST_ROW, BLANK, 8'(COLS)};
  localparam wr_op_t OP_BLANK = {LAST_ROW, SCREEN, BLANK, 8'd0};

  // row*COLS+col as shifts: 80 = 64 + 16
  function automatic logic [10:0] lin(
    input logic [4:0] row,
    input logic [6:0] col
  );
    lin = {row, 6'b0} + {2'b0, row, 4'b0} + {4'b0, col};
  endfunction

endpackage

// File: rtl/term_wr_port.sv
// Bulk write port sequencer: holds one operation,
// pulses wr_start and tracks completion.
module term_wr_port
  import term_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   issue_i,
  input  wr_op_t op_i,
  input  logic   wr_complete_i,
  output logic   wr_start_o,
  output wr_op_t op_o,
  output logic   busy_o,
  output logic   done_o
);

  logic   start_q;
  logic   wait_q;
  wr_op_t op_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      start_q <= 1'b0;
      wait_q  <= 1'b0;
      op_q    <= {11'd0, 11'd0, BLANK, 8'd0};
    end else begin
      start_q <= issue_i && !busy_o;
      if (issue_i && !busy_o)
        op_q <= op_i;
      // completion only counts once the start pulse is over
      if (start_q)
        wait_q <= 1'b1;
      else if (wr_complete_i)
        wait_q <= 1'b0;
    end
  end

  assign busy_o     = start_q | wait_q;
  assign done_o     = wait_q & wr_complete_i;
  assign wr_start_o = start_q;
  assign op_o       = op_q;

endmodule

// File: rtl/term_ctrl.sv
// Character-stream controller: turns bytes into
// fill/copy operations on the text-mode index RAM.
module term_ctrl
  import term_pkg::*;
#(
  parameter logic [15:0] INIT_DELAY = 16'hFFFF
) (
  input  logic        clk100,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [10:0] cursor,
  output logic        wr_start,
  output logic [10:0] wr_begin,
  output logic [10:0] wr_end,
  output logic [7:0]  wr_data,
  output logic [7:0]  wr_offset,
  input  logic        wr_complete
);

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [6:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;
  logic [10:0] cursor_q;
  logic [7:0]  byte_q;
  logic [1:0]  sc_q, sc_d;
  logic        rdy_q;
  logic        want;
  logic        issue;
  logic        busy;
  logic        done;
  logic        printable;
  wr_op_t      op;
  wr_op_t      op_out;

  assign printable = (byte_q >= 8'h20) && (byte_q <= 8'h7E);

  // sc counts scroll operations still to issue: 2 = copy next, 1 = blank row
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    sc_d  = 2'd0;
    want  = 1'b0;
    op    = OP_CLEAR;
    unique case (state_q)
      S_INIT_CLR: want = 1'b1;
      S_DECODE: begin
        unique case (1'b1)
          printable: begin
            want = 1'b1;
            op   = {cursor_q, cursor_q + 11'd1, byte_q, 8'd0};
            if (col_q == COL_MAX) begin
              col_d = '0;
              if (row_q == ROW_MAX)
                sc_d = 2'd2;
              else
                row_d = row_q + 5'd1;
            end else begin
              col_d = col_q + 7'd1;
            end
          end
          (byte_q == LF): begin
            if (row_q == ROW_MAX) begin
              want = 1'b1;
              op   = OP_COPY;
              sc_d = 2'd1;
            end else begin
              row_d = row_q + 5'd1;
            end
          end
          (byte_q == CR): col_d = '0;
          (byte_q == BS): begin
            if (col_q != '0)
              col_d = col_q - 7'd1;
          end
          (byte_q == FF): begin
            want  = 1'b1;
            col_d = '0;
            row_d = '0;
          end
          default: ;
        endcase
      end
      S_NEXT: begin
        want = (sc_q != 2'd0);
        op   = (sc_q == 2'd2) ? OP_COPY : OP_BLANK;
      end
      default: ;
    endcase
  end

  assign issue = want & ~busy;

  always_ff @(posedge clk100) begin
    if (!rst_n) begin
      state_q  <= S_INIT_WAIT;
      cnt_q    <= '0;
      col_q    <= '0;
      row_q    <= '0;
      cursor_q <= '0;
      byte_q   <= '0;
      sc_q     <= '0;
      rdy_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_INIT_WAIT: begin
          if (cnt_q == INIT_DELAY - 16'd1)
            state_q <= S_INIT_CLR;
          else
            cnt_q <= cnt_q + 16'd1;
        end
        S_INIT_CLR: begin
          col_q    <= '0;
          row_q    <= '0;
          cursor_q <= '0;
          sc_q     <= '0;
          state_q  <= S_ISSUE;
        end
        S_IDLE: begin
          if (in_valid && rdy_q) begin
            byte_q  <= in_data;
            rdy_q   <= 1'b0;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          col_q <= col_d;
          row_q <= row_d;
          sc_q  <= sc_d;
          if (want) begin
            state_q <= S_ISSUE;
          end else begin
            rdy_q    <= 1'b1;
            cursor_q <= lin(row_d, col_d);
            state_q  <= S_IDLE;
          end
        end
        S_ISSUE: state_q <= S_WAIT;
        S_WAIT: begin
          if (done)
            state_q <= S_NEXT;
        end
        S_NEXT: begin
          if (sc_q != 2'd0) begin
            sc_q    <= sc_q - 2'd1;
            state_q <= S_ISSUE;
          end else begin
            rdy_q    <= 1'b1;
            cursor_q <= lin(row_q, col_q);
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_INIT_WAIT;
      endcase
    end
  end

  term_wr_port u_wr (
    .clk_i         (clk100),
    .rst_ni        (rst_n),
    .issue_i       (issue),
    .op_i          (op),
    .wr_complete_i (wr_complete),
    .wr_start_o    (wr_start),
    .op_o          (op_out),
    .busy_o        (busy),
    .done_o        (done)
  );

  assign in_ready  = rdy_q;
  assign cursor    = cursor_q;
  assign wr_begin  = op_out.addr_b;
  assign wr_end    = op_out.addr_e;
  assign wr_data   = op_out.data;
  assign wr_offset = op_out.off;

endmodule
